multicycle_controller: RTL and testbench

Multi-cycle control unit for the RV32I core. It sequences each instruction through fetch, decode, execute and writeback states and drives the datapath mux selects and write strobes. It is the producer of the 3-bit ALU operation code and the consumer of the ALU's V/N/Zero flags, and it evaluates branch conditions from those flags.

---
 rtl/multicycle_controller_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the RV32I multi-cycle controller
package multicycle_controller_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7 to ALU operation decode with unsupported-encoding detect
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] ALUControl,
    output logic       alu_illegal
);

    logic is_r;
    logic is_i;

    assign is_r = (op == OP_RTYPE);
    assign is_i = (op == OP_ITYPE);

    always_comb begin
        ALUControl  = ALU_ADD;
        alu_illegal = 1'b0;
        case (funct3)
            3'b000: ALUControl = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: ALUControl = ALU_SLL;
            3'b010: ALUControl = ALU_SLT;
            3'b011: alu_illegal = is_r || is_i;
            3'b100: ALUControl = ALU_XOR;
            3'b101: begin
                ALUControl = ALU_SRL;
                // funct7b5 selects SRA, which this core does not implement
                if (funct7b5 && (is_r || is_i))
                    alu_illegal = 1'b1;
            end
            3'b110: ALUControl = ALU_OR;
            3'b111: ALUControl = ALU_AND;
            default: ALUControl = ALU_ADD;
        endcase
        if (is_r && funct3 != 3'b000 && funct7b5)
            alu_illegal = 1'b1;
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle control FSM driving datapath selects and strobes
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       N,
    input  logic       V,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal_instr,
    output logic       retire
);

    state_t     state;
    state_t     next_state;
    logic [2:0] dec_alu_control;
    logic       alu_illegal;
    logic       branch_taken;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_pulse;
    logic       retire_pulse;

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .ALUControl  (dec_alu_control),
        .alu_illegal (alu_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = Zero;
            3'b001: branch_taken = !Zero;
            3'b100: branch_taken = N ^ V;
            3'b101: branch_taken = !(N ^ V);
            default: branch_taken = 1'b0;
        endcase
    end

    assign ImmSrc = imm_src_of(op);

    always_comb begin
        next_state    = S_FETCH;
        ALUControl    = ALU_ADD;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ResultSrc     = RES_ALUOUT;
        AdrSrc        = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        illegal_pulse = 1'b0;
        retire_pulse  = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while the opcode is examined
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:  next_state = alu_illegal ? S_FETCH : S_EXECUTER;
                    OP_ITYPE:  next_state = alu_illegal ? S_FETCH : S_EXECUTEI;
                    OP_BRANCH: next_state = funct3[1] ? S_FETCH : S_BRANCH;
                    OP_JAL:    next_state = S_JAL;
                    default:   next_state = S_FETCH;
                endcase
                illegal_pulse = (next_state == S_FETCH);
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = RES_MEMDATA;
                reg_write    = 1'b1;
                retire_pulse = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                mem_write    = 1'b1;
                retire_pulse = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = dec_alu_control;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu_control;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                retire_pulse = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_RS2;
                ALUControl   = ALU_SUB;
                pc_write     = branch_taken;
                retire_pulse = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Strobes are gated directly by reset so an aborted store cannot commit
    assign PCWrite       = pc_write      & ~reset;
    assign IRWrite       = ir_write      & ~reset;
    assign RegWrite      = reg_write     & ~reset;
    assign MemWrite      = mem_write     & ~reset;
    assign illegal_instr = illegal_pulse & ~reset;
    assign retire        = retire_pulse  & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard testbench for multicycle_controller
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, N, V;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic       AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, illegal_instr, retire;

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [17:0] act;
    assign act = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
                  PCWrite, IRWrite, RegWrite, MemWrite, illegal_instr, retire};

    multicycle_controller dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .Zero          (Zero),
        .N             (N),
        .V             (V),
        .ALUControl    (ALUControl),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ResultSrc     (ResultSrc),
        .ImmSrc        (ImmSrc),
        .AdrSrc        (AdrSrc),
        .PCWrite       (PCWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .illegal_instr (illegal_instr),
        .retire        (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pk(input logic [2:0] alu, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [1:0] imm, input logic adr,
                                       input logic pcw, input logic irw, input logic rw, input logic mw,
                                       input logic ill, input logic ret);
        return {alu, sa, sb, rs, imm, adr, pcw, irw, rw, mw, ill, ret};
    endfunction

    function automatic logic [1:0] imm_for(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [17:0] e_reset(input logic [1:0] i);    return pk(3'b000, 2'b00, 2'b10, 2'b10, i, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic logic [17:0] e_fetch(input logic [1:0] i);    return pk(3'b000, 2'b00, 2'b10, 2'b10, i, 0, 1, 1, 0, 0, 0, 0); endfunction
    function automatic logic [17:0] e_decode(input logic [1:0] i, input logic ill);
                                                                     return pk(3'b000, 2'b01, 2'b01, 2'b00, i, 0, 0, 0, 0, 0, ill, 0); endfunction
    function automatic logic [17:0] e_memadr(input logic [1:0] i);   return pk(3'b000, 2'b10, 2'b01, 2'b00, i, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic logic [17:0] e_memread(input logic [1:0] i);  return pk(3'b000, 2'b00, 2'b00, 2'b00, i, 1, 0, 0, 0, 0, 0, 0); endfunction
    function automatic logic [17:0] e_memwb(input logic [1:0] i);    return pk(3'b000, 2'b00, 2'b00, 2'b01, i, 0, 0, 0, 1, 0, 0, 1); endfunction
    function automatic logic [17:0] e_memwrite(input logic [1:0] i); return pk(3'b000, 2'b00, 2'b00, 2'b00, i, 1, 0, 0, 0, 1, 0, 1); endfunction
    function automatic logic [17:0] e_execr(input logic [1:0] i, input logic [2:0] a);
                                                                     return pk(a, 2'b10, 2'b00, 2'b00, i, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic logic [17:0] e_execi(input logic [1:0] i, input logic [2:0] a);
                                                                     return pk(a, 2'b10, 2'b01, 2'b00, i, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic logic [17:0] e_aluwb(input logic [1:0] i);    return pk(3'b000, 2'b00, 2'b00, 2'b00, i, 0, 0, 0, 1, 0, 0, 1); endfunction
    function automatic logic [17:0] e_branch(input logic [1:0] i, input logic tk);
                                                                     return pk(3'b001, 2'b10, 2'b00, 2'b00, i, 0, tk, 0, 0, 0, 0, 1); endfunction
    function automatic logic [17:0] e_jal(input logic [1:0] i);      return pk(3'b000, 2'b01, 2'b10, 2'b00, i, 0, 1, 0, 0, 0, 0, 0); endfunction

    task automatic push(input string tag, input logic [17:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic n, input logic v);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; N = n; V = v;
    endtask

    task automatic test_reset;
        exp_t e;
        reset = 1'b1;
        drive(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            push($sformatf("reset_hold%0d", c), e_reset(2'b00));
            @(negedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
            end
        end
        reset = 1'b0;
        push("sub_fetch", e_fetch(2'b00));
        push("sub_decode", e_decode(2'b00, 1'b0));
        push("sub_execr", e_execr(2'b00, 3'b001));
        push("sub_aluwb", e_aluwb(2'b00));
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw;
        exp_t e;
        drive(7'b0000011, 3'b010, $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
        push("lw_fetch", e_fetch(2'b00));
        push("lw_decode", e_decode(2'b00, 1'b0));
        push("lw_memadr", e_memadr(2'b00));
        push("lw_memread", e_memread(2'b00));
        push("lw_memwb", e_memwb(2'b00));
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch;
        exp_t e;
        logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b000, 3'b001, 3'b100, 3'b101};
        logic       zs  [8] = '{1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
        logic       ns  [8] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0};
        logic       vs  [8] = '{1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
        logic       tks [8] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
        for (int k = 0; k < 8; k++) begin
            drive(7'b1100011, f3s[k], 1'b0, zs[k], ns[k], vs[k]);
            push($sformatf("br%0d_fetch", k), e_fetch(2'b10));
            push($sformatf("br%0d_decode", k), e_decode(2'b10, 1'b0));
            push($sformatf("br%0d_f3_%b_taken", k, f3s[k]), e_branch(2'b10, tks[k]));
            while (exp_q.size() > 0) begin
                #1;
                e = exp_q.pop_front();
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_itype;
        exp_t e;
        logic [2:0] f3s [4] = '{3'b001, 3'b010, 3'b000, 3'b011};
        logic       f7s [4] = '{1'b0,   1'b0,   1'b1,   1'b0};
        logic [2:0] als [4] = '{3'b101, 3'b111, 3'b000, 3'b000};
        for (int k = 0; k < 4; k++) begin
            drive(7'b0010011, f3s[k], f7s[k], $urandom_range(1), $urandom_range(1), $urandom_range(1));
            push($sformatf("itype_f3_%b_fetch", f3s[k]), e_fetch(2'b00));
            if (f3s[k] == 3'b011) begin
                push("itype_sltu_illegal", e_decode(2'b00, 1'b1));
            end else begin
                push($sformatf("itype_f3_%b_decode", f3s[k]), e_decode(2'b00, 1'b0));
                push($sformatf("itype_f3_%b_exec", f3s[k]), e_execi(2'b00, als[k]));
                push($sformatf("itype_f3_%b_aluwb", f3s[k]), e_aluwb(2'b00));
            end
            while (exp_q.size() > 0) begin
                #1;
                e = exp_q.pop_front();
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
                end
                @(negedge clk);
            end
        end
        drive(7'b0010011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        push("after_illegal_fetch", e_fetch(2'b00));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (act !== e.v) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
        end
        // the FETCH just checked is consumed by the next task's own FETCH check
    endtask

    task automatic test_illegal;
        exp_t e;
        logic [6:0] ops [4] = '{7'b0000000, 7'b1100011, 7'b0110011, 7'b0010011};
        logic [2:0] f3s [4] = '{3'b000,     3'b010,     3'b001,     3'b101};
        logic       f7s [4] = '{1'b0,       1'b0,       1'b1,       1'b1};
        for (int k = 0; k < 4; k++) begin
            drive(ops[k], f3s[k], f7s[k], $urandom_range(1), $urandom_range(1), $urandom_range(1));
            push($sformatf("illegal%0d_fetch", k), e_fetch(imm_for(ops[k])));
            push($sformatf("illegal%0d_decode", k), e_decode(imm_for(ops[k]), 1'b1));
            while (exp_q.size() > 0) begin
                #1;
                e = exp_q.pop_front();
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_sw_reset;
        exp_t e;
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        push("sw_fetch", e_fetch(2'b01));
        push("sw_decode", e_decode(2'b01, 1'b0));
        push("sw_memadr", e_memadr(2'b01));
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
            end
            @(negedge clk);
        end
        push("sw_memwrite", e_memwrite(2'b01));
        push("sw_reset_same_cycle", e_reset(2'b01));
        push("sw_reset_held", e_reset(2'b01));
        push("sw_fetch_after_release", e_fetch(2'b01));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (act !== e.v) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
        end
        reset = 1'b1;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (act !== e.v) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (act !== e.v) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
        end
        reset = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (act !== e.v) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
        end
        @(negedge clk);
    endtask

    task automatic test_jal;
        exp_t e;
        drive(7'b1101111, 3'b000, 1'b0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
        push("jal_fetch", e_fetch(2'b11));
        push("jal_decode", e_decode(2'b11, 1'b0));
        push("jal_jal", e_jal(2'b11));
        push("jal_aluwb", e_aluwb(2'b11));
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [2:0] f3s [7] = '{3'b000, 3'b110, 3'b111, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [2:0] als [7] = '{3'b000, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111};
        for (int k = 0; k < 7; k++) begin
            drive(7'b0110011, f3s[k], 1'b0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
            push($sformatf("rtype_f3_%b_fetch", f3s[k]), e_fetch(2'b00));
            push($sformatf("rtype_f3_%b_decode", f3s[k]), e_decode(2'b00, 1'b0));
            push($sformatf("rtype_f3_%b_exec", f3s[k]), e_execr(2'b00, als[k]));
            push($sformatf("rtype_f3_%b_aluwb", f3s[k]), e_aluwb(2'b00));
            while (exp_q.size() > 0) begin
                #1;
                e = exp_q.pop_front();
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s actual=%b expected=%b", e.tag, act, e.v);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_itype();
        test_illegal();
        test_sw_reset();
        test_jal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
